// File: rtl/sha256_msg_sequencer.sv
// Feeds a SHA-256 core's word-write port from a byte stream and appends the
// 0x80 marker, zero fill and 64-bit length. One 512-bit block is released per core_done.
module sha256_msg_sequencer #(
  parameter int unsigned LEN_W = 32
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [2:0]  s_nbytes,
  output logic        core_init,
  output logic        core_wr_valid,
  input  logic        core_wr_ready,
  output logic [31:0] core_wr_data,
  input  logic        core_done,
  output logic        busy,
  output logic        done,
  output logic        len_err
);

  localparam int unsigned SUM_W = LEN_W + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_DATA,
    S_PAD80,
    S_ZERO,
    S_LEN_HI,
    S_LEN_LO,
    S_WAIT_CORE,
    S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           r_resume;
  state_t           w_resume_nxt;
  state_t           w_blk_nxt;
  state_t           w_pad_nxt;
  logic [3:0]       r_word_idx;
  logic [LEN_W-1:0] r_byte_cnt;
  logic             r_len_err;
  logic             w_xfer;
  logic [SUM_W-1:0] w_cnt_sum;
  logic [63:0]      w_bit_len;
  logic [31:0]      w_data_word;

  assign w_bit_len = 64'({r_byte_cnt, 3'b000});
  assign w_cnt_sum = {1'b0, r_byte_cnt} + SUM_W'(s_nbytes);
  assign len_err   = r_len_err;

  // Short tail beat: keep lanes 0..n-1, put the 0x80 marker in lane n, zero above.
  always_comb begin
    w_data_word = s_data;
    if (s_last && (s_nbytes < 3'd4)) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < s_nbytes) begin
          w_data_word[8*k +: 8] = s_data[8*k +: 8];
        end else if (3'(k) == s_nbytes) begin
          w_data_word[8*k +: 8] = 8'h80;
        end else begin
          w_data_word[8*k +: 8] = 8'h00;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= S_IDLE;
      r_resume <= S_IDLE;
    end else begin
      r_state  <= w_state_nxt;
      r_resume <= w_resume_nxt;
    end
  end

  // A padding word at index 13 is always followed by the length pair at 14/15.
  always_comb begin
    w_state_nxt   = r_state;
    w_resume_nxt  = r_resume;
    w_blk_nxt     = r_state;
    w_pad_nxt     = (r_word_idx == 4'd13) ? S_LEN_HI : S_ZERO;
    s_ready       = 1'b0;
    core_wr_valid = 1'b0;
    core_wr_data  = 32'h0000_0000;
    core_init     = 1'b0;
    done          = 1'b0;
    busy          = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_INIT;
      end
      S_INIT: begin
        core_init   = 1'b1;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        s_ready       = core_wr_ready;
        core_wr_valid = s_valid;
        core_wr_data  = w_data_word;
        if (!s_last) begin
          w_blk_nxt = S_DATA;
        end else if (s_nbytes >= 3'd4) begin
          w_blk_nxt = S_PAD80;
        end else begin
          w_blk_nxt = w_pad_nxt;
        end
      end
      S_PAD80: begin
        core_wr_valid = 1'b1;
        core_wr_data  = 32'h0000_0080;
        w_blk_nxt     = w_pad_nxt;
      end
      S_ZERO: begin
        core_wr_valid = 1'b1;
        w_blk_nxt     = w_pad_nxt;
      end
      S_LEN_HI: begin
        core_wr_valid = 1'b1;
        core_wr_data  = {w_bit_len[39:32], w_bit_len[47:40], w_bit_len[55:48], w_bit_len[63:56]};
        w_blk_nxt     = S_LEN_LO;
      end
      S_LEN_LO: begin
        core_wr_valid = 1'b1;
        core_wr_data  = {w_bit_len[7:0], w_bit_len[15:8], w_bit_len[23:16], w_bit_len[31:24]};
        w_blk_nxt     = S_FIN;
      end
      S_WAIT_CORE: begin
        if (core_done) w_state_nxt = r_resume;
      end
      S_FIN: begin
        busy        = 1'b0;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_xfer = core_wr_valid & core_wr_ready;
    if (w_xfer) begin
      if (r_word_idx == 4'd15) begin
        w_state_nxt  = S_WAIT_CORE;
        w_resume_nxt = w_blk_nxt;
      end else begin
        w_state_nxt = w_blk_nxt;
      end
    end
  end

  // Block word index and saturating message byte count.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_word_idx <= 4'd0;
      r_byte_cnt <= '0;
      r_len_err  <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_word_idx <= 4'd0;
      r_byte_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_xfer) r_word_idx <= r_word_idx + 4'd1;
      if (w_xfer && (r_state == S_DATA)) begin
        if (w_cnt_sum[LEN_W]) begin
          r_byte_cnt <= '1;
          r_len_err  <= 1'b1;
        end else begin
          r_byte_cnt <= w_cnt_sum[LEN_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Scoreboard bench: a byte-level padding model fills expected-word queues and a
// monitor that also plays the core checks every word, done pulse and len_err.
module tb_sha256_msg_sequencer;

  typedef logic [7:0] bq_t[$];

  logic        aclk = 1'b0;
  logic        areset, start, s_valid, s_last, core_wr_ready, core_done;
  logic [31:0] s_data;
  logic [2:0]  s_nbytes;
  logic        s_ready, core_init, core_wr_valid, busy, done, len_err;
  logic [31:0] core_wr_data;
  logic        s_ready4, core_init4, core_wr_valid4, busy4, done4, len_err4;
  logic [31:0] core_wr_data4;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  bit          experr0[$];
  bit          experr1[$];
  int          blk_cnt = 0;
  int          lat = 0;
  int          stall = 0;
  int          init_cnt = 0;
  bit          pending = 1'b0;

  always #5 aclk = ~aclk;

  sha256_msg_sequencer #(.LEN_W(32)) u_dut (
    .aclk(aclk), .areset(areset), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_nbytes(s_nbytes),
    .core_init(core_init), .core_wr_valid(core_wr_valid), .core_wr_ready(core_wr_ready),
    .core_wr_data(core_wr_data), .core_done(core_done),
    .busy(busy), .done(done), .len_err(len_err)
  );

  // Narrow counter instance sharing all inputs; only its length words and len_err differ.
  sha256_msg_sequencer #(.LEN_W(4)) u_dut4 (
    .aclk(aclk), .areset(areset), .start(start),
    .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data), .s_last(s_last), .s_nbytes(s_nbytes),
    .core_init(core_init4), .core_wr_valid(core_wr_valid4), .core_wr_ready(core_wr_ready),
    .core_wr_data(core_wr_data4), .core_done(core_done),
    .busy(busy4), .done(done4), .len_err(len_err4)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %h, expected no such event", name, act);
  endfunction

  function automatic bq_t rand_msg(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Padding model on the byte stream: msg, 0x80, zeros to 56 mod 64, big-endian bit length.
  task automatic push_exp(input bq_t m);
    bq_t             p;
    longint unsigned n;
    longint unsigned cap;
    logic [63:0]     bl;
    logic [31:0]     w;
    for (int d = 0; d < 2; d++) begin
      p = m;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      cap = (d == 0) ? 64'hFFFF_FFFF : 64'hF;
      n = 64'(m.size());
      if (n > cap) n = cap;
      bl = 64'(n << 3);
      for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
      for (int j = 0; j < p.size() / 4; j++) begin
        w = {p[4*j+3], p[4*j+2], p[4*j+1], p[4*j]};
        if (d == 0) exp0.push_back(w);
        else exp1.push_back(w);
      end
      if (d == 0) experr0.push_back(64'(m.size()) > cap);
      else experr1.push_back(64'(m.size()) > cap);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ctrl"}, 32'({s_ready, core_init, core_wr_valid, busy, done, len_err}), 32'd0);
    chk({tag, "_data"}, core_wr_data, 32'd0);
    chk({tag, "_ctrl4"}, 32'({s_ready4, core_init4, core_wr_valid4, busy4, done4, len_err4}), 32'd0);
    chk({tag, "_data4"}, core_wr_data4, 32'd0);
  endtask

  // Called at a negedge; returns at a negedge after the beat is taken or the budget expires.
  task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] nb,
                           input logic pulse_start, output bit ok);
    int guard;
    bit hs;
    guard   = 0;
    hs      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_nbytes = nb;
    start   = pulse_start;
    while (!hs && guard < 500) begin
      #4;
      hs = s_ready;
      @(negedge aclk);
      start = 1'b0;
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    ok = hs;
    if (!hs) fail_now("beat_accept_timeout", d);
  endtask

  task automatic send_msg(input bq_t m, input bit tail_empty);
    int          len;
    int          nbeats;
    logic [31:0] d;
    logic [2:0]  nb;
    bit          ok;
    bit          idle;
    len = m.size();
    @(negedge aclk);
    push_exp(m);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    nbeats = ((len % 4) != 0 || len == 0 || tail_empty) ? len / 4 + 1 : len / 4;
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(0, 3) == 0) @(negedge aclk);
      d  = $urandom;
      nb = (4 * b + 4 <= len) ? 3'd4 : 3'(len - 4 * b);
      for (int k = 0; k < 4; k++) begin
        if (4 * b + k < len) d[8*k +: 8] = m[4*b+k];
      end
      // beat 1 also carries a start pulse, which must be ignored while busy
      send_beat(d, (b == nbeats - 1), nb, (b == 1), ok);
      if (!ok) return;
    end
    idle = 1'b0;
    for (int g = 0; g < 3000; g++) begin
      #4;
      if (!busy) begin
        idle = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    if (!idle) fail_now("done_timeout", 32'(len));
  endtask

  // Monitor and core model: random ready with a 3-cycle stall mid-block, core_done after each block.
  initial begin : monitor
    bit x0;
    bit x1;
    core_wr_ready = 1'b0;
    core_done     = 1'b0;
    forever begin
      @(negedge aclk);
      core_done = 1'b0;
      if (pending) begin
        if (lat == 0) begin
          core_done = 1'b1;
          pending   = 1'b0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        core_done = 1'b1;
      end
      if (stall > 0) begin
        core_wr_ready = 1'b0;
        stall--;
      end else begin
        core_wr_ready = ($urandom_range(0, 3) != 0);
      end
      #4;
      if (areset) begin
        blk_cnt  = 0;
        pending  = 1'b0;
        stall    = 0;
        init_cnt = 0;
      end else begin
        x0 = core_wr_valid && core_wr_ready;
        x1 = core_wr_valid4 && core_wr_ready;
        if (busy || busy4)
          chk("lockstep_ctrl", 32'({s_ready4, core_init4, core_wr_valid4, busy4, done4}),
              32'({s_ready, core_init, core_wr_valid, busy, done}));
        if (busy && !core_wr_ready) chk("s_ready_while_core_stalled", 32'(s_ready), 32'd0);
        if (x0) begin
          if (exp0.size() == 0) fail_now("unexpected_word", core_wr_data);
          else chk("word", core_wr_data, exp0.pop_front());
          blk_cnt++;
          if (blk_cnt == 8) stall = 3;
          if (blk_cnt == 16) begin
            blk_cnt = 0;
            pending = 1'b1;
            lat     = $urandom_range(0, 4);
          end
        end
        if (x1) begin
          if (exp1.size() == 0) fail_now("unexpected_word_len4", core_wr_data4);
          else chk("word_len4", core_wr_data4, exp1.pop_front());
        end
        if (core_init) init_cnt++;
        if (done) begin
          chk("init_pulses_per_msg", 32'(init_cnt), 32'd1);
          init_cnt = 0;
          chk("words_left_at_done", 32'(exp0.size()), 32'd0);
          chk("pending_block_at_done", 32'({pending, 28'(blk_cnt)}), 32'd0);
          if (experr0.size() == 0) fail_now("unexpected_done", 32'(len_err));
          else chk("len_err", 32'(len_err), 32'(experr0.pop_front()));
          if (experr1.size() == 0) fail_now("unexpected_done_len4", 32'(len_err4));
          else chk("len_err_len4", 32'(len_err4), 32'(experr1.pop_front()));
        end
      end
    end
  end

  initial begin : driver
    bq_t         m;
    logic [31:0] pw[7];
    bit          ok;
    bit          drained;
    areset   = 1'b1;
    start    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 32'd0;
    s_last   = 1'b0;
    s_nbytes = 3'd0;
    repeat (3) @(negedge aclk);
    #4;
    check_idle("reset");
    @(negedge aclk);
    areset = 1'b0;

    m = rand_msg(64); send_msg(m, 1'b0);
    m = {};           send_msg(m, 1'b1);
    m = {8'h61, 8'h62, 8'h63}; send_msg(m, 1'b0);
    m = rand_msg(56); send_msg(m, 1'b0);
    m = rand_msg(55); send_msg(m, 1'b0);
    m = rand_msg(15); send_msg(m, 1'b0);
    m = rand_msg(16); send_msg(m, 1'b0);
    m = rand_msg(16); send_msg(m, 1'b1);

    // Seven words into a message, then reset: nothing further may reach the core.
    @(negedge aclk);
    for (int i = 0; i < 7; i++) begin
      pw[i] = $urandom;
      exp0.push_back(pw[i]);
      exp1.push_back(pw[i]);
    end
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_beat(pw[i], 1'b0, 3'd4, 1'b0, ok);
      if (!ok) break;
    end
    drained = 1'b0;
    for (int g = 0; g < 500; g++) begin
      #4;
      if (exp0.size() == 0) begin
        drained = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    if (!drained) fail_now("partial_drain_timeout", 32'(exp0.size()));
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    #4;
    check_idle("after_areset");
    exp0.delete();
    exp1.delete();

    m = {8'h61, 8'h62, 8'h63}; send_msg(m, 1'b0);
    for (int r = 0; r < 25; r++) begin
      m = rand_msg($urandom_range(0, 140));
      send_msg(m, 1'($urandom_range(0, 1)));
    end

    repeat (20) @(negedge aclk);
    chk("leftover_words", 32'(exp0.size() + exp1.size()), 32'd0);
    chk("leftover_dones", 32'(experr0.size() + experr1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
